mem_port_arbiter: RTL and testbench

//  Shares one 128-bit line-fill/write-back memory port between two cache controllers
//  (port 0 = instruction cache, port 1 = data cache). Round-robin, one transaction at
//  a time. Registered memory-side outputs; response returned with a one-cycle ready

---
 rtl/mem_port_arbiter_pkg.sv | 16 +
 rtl/mem_port_arbiter_rr_pick2.sv | 27 ++
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter.
//  - arb_state_e : arbiter FSM encodings (IDLE / ISSUE / RESP)
//  - PORT_I      : index of the instruction-cache port
//  - PORT_D      : index of the data-cache port
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_e;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker.
// Ports:
//  valid [1:0] in  : per-port request flags
//  last        in  : port granted most recently
//  grant       out : chosen port (meaningful only when any=1)
//  any         out : at least one port is requesting
module mem_port_arbiter_rr_pick2
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last,
    output logic       grant,
    output logic       any
);

    always_comb begin
        any   = |valid;
        grant = PORT_I;
        if (&valid) begin
            // Contention: the port that did not win last time goes next.
            grant = ~last;
        end else if (valid[PORT_D]) begin
            grant = PORT_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one line-wide memory port between the instruction cache (port 0) and
// the data cache (port 1). One transaction in flight, round-robin on contention,
// registered memory-side outputs, one-cycle completion pulse back to the owner,
// and an abort with error pulse if memory does not answer within TIMEOUT cycles.
// Ports:
//  clk, r_n                 : clock, asynchronous active-low reset
//  req_valid/rw/addr/wdata  : per-port requests, port p in slice p
//  req_ready/req_err        : one-cycle completion / timeout pulse to the owner
//  req_rdata                : last read line, updated only on successful reads
//  mem_valid/rw/addr/wdata  : registered request to memory, held until mem_ready
//  mem_rdata/mem_ready      : memory response, sampled only while issuing
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  r_n,
    input  logic [1:0]            req_valid,
    input  logic [1:0]            req_rw,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*LINE_W-1:0]   req_wdata,
    output logic [1:0]            req_ready,
    output logic [1:0]            req_err,
    output logic [LINE_W-1:0]     req_rdata,
    output logic                  mem_valid,
    output logic                  mem_rw,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [LINE_W-1:0]     mem_wdata,
    input  logic [LINE_W-1:0]     mem_rdata,
    input  logic                  mem_ready
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // Last ISSUE cycle index; cnt starts at 0 so mem_valid stays up TIMEOUT cycles.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_valid_q, mem_valid_d;
    logic              mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]        req_ready_q, req_ready_d;
    logic [1:0]        req_err_q, req_err_d;
    logic [LINE_W-1:0] req_rdata_q, req_rdata_d;

    logic              pick_grant;
    logic              pick_any;

    // Split the flat request buses into per-port views.
    logic [ADDR_W-1:0] port_addr  [2];
    logic [LINE_W-1:0] port_wdata [2];
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign port_addr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
        assign port_wdata[gi] = req_wdata[gi*LINE_W +: LINE_W];
    end

    mem_port_arbiter_rr_pick2 u_pick (
        .valid (req_valid),
        .last  (last_grant_q),
        .grant (pick_grant),
        .any   (pick_any)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        mem_valid_d  = mem_valid_q;
        mem_rw_d     = mem_rw_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        req_ready_d  = 2'b00;
        req_err_d    = 2'b00;
        req_rdata_d  = req_rdata_q;

        case (state_q)
            ST_IDLE: begin
                mem_valid_d = 1'b0;
                if (pick_any) begin
                    owner_d      = pick_grant;
                    last_grant_d = pick_grant;
                    mem_valid_d  = 1'b1;
                    mem_rw_d     = req_rw[pick_grant];
                    mem_addr_d   = port_addr[pick_grant];
                    mem_wdata_d  = port_wdata[pick_grant];
                    cnt_d        = '0;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // mem_ready wins over a coincident timeout.
                if (mem_ready) begin
                    mem_valid_d          = 1'b0;
                    req_ready_d[owner_q] = 1'b1;
                    if (!mem_rw_q) begin
                        req_rdata_d = mem_rdata;
                    end
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    mem_valid_d          = 1'b0;
                    req_ready_d[owner_q] = 1'b1;
                    req_err_d[owner_q]   = 1'b1;
                    state_d              = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                // Pulses clear via the defaults above.
                state_d = ST_IDLE;
            end
            default: begin
                mem_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= PORT_I;
            last_grant_q <= PORT_D;
            cnt_q        <= '0;
            mem_valid_q  <= 1'b0;
            mem_rw_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            req_ready_q  <= 2'b00;
            req_err_q    <= 2'b00;
            req_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            mem_valid_q  <= mem_valid_d;
            mem_rw_q     <= mem_rw_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            req_ready_q  <= req_ready_d;
            req_err_q    <= req_err_d;
            req_rdata_q  <= req_rdata_d;
        end
    end

    assign req_ready = req_ready_q;
    assign req_err   = req_err_q;
    assign req_rdata = req_rdata_q;
    assign mem_valid = mem_valid_q;
    assign mem_rw    = mem_rw_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (TIMEOUT=8). Stimulus pushes commands to
// per-port drivers plus the expected memory request and response; a memory
// responder checks requests as they appear and a response monitor checks every
// req_ready/req_err pulse against the expected queue.
module tb_mem_port_arbiter;

    localparam int ADDR_W  = 32;
    localparam int LINE_W  = 128;
    localparam int TIMEOUT = 8;

    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic signed [31:0] delay;  // >=1 cycles to mem_ready, -1 timeout, -2 reset abort
        logic [LINE_W-1:0]  rdata;
    } mresp_t;

    typedef struct packed {
        logic [1:0]        rdy;
        logic [1:0]        err;
        logic [LINE_W-1:0] rdata;
    } resp_t;

    logic                clk = 1'b0;
    logic                r_n = 1'b1;
    wire  [1:0]          req_valid;
    wire  [1:0]          req_rw;
    wire  [2*ADDR_W-1:0] req_addr;
    wire  [2*LINE_W-1:0] req_wdata;
    logic [1:0]          req_ready;
    logic [1:0]          req_err;
    logic [LINE_W-1:0]   req_rdata;
    logic                mem_valid;
    logic                mem_rw;
    logic [ADDR_W-1:0]   mem_addr;
    logic [LINE_W-1:0]   mem_wdata;
    logic [LINE_W-1:0]   mem_rdata = '0;
    logic                mem_ready = 1'b0;

    cmd_t   cmd_q [2][$];
    cmd_t   exp_mem[$];
    mresp_t mem_q[$];
    resp_t  exp_resp[$];

    int n_vec = 0;
    int n_err = 0;
    int n_resp = 0;
    int stray_cnt = 0;
    int stray_done = 0;
    logic [LINE_W-1:0] model_rd = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W  (ADDR_W),
        .LINE_W  (LINE_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .r_n       (r_n),
        .req_valid (req_valid),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .req_err   (req_err),
        .req_rdata (req_rdata),
        .mem_valid (mem_valid),
        .mem_rw    (mem_rw),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    task automatic check(input string name, input logic [299:0] act, input logic [299:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_msg(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s", name);
    endtask

    // Queue one transaction; calls must be made in the expected grant order.
    task automatic txn(input int p, input logic rw, input logic [ADDR_W-1:0] addr,
                       input logic [LINE_W-1:0] wdata, input int delay,
                       input logic [LINE_W-1:0] mdata);
        cmd_t   c;
        mresp_t m;
        resp_t  r;
        c.rw = rw; c.addr = addr; c.wdata = wdata;
        cmd_q[p].push_back(c);
        exp_mem.push_back(c);
        m.delay = delay; m.rdata = mdata;
        mem_q.push_back(m);
        if (delay != -2) begin
            if (delay > 0 && !rw) model_rd = mdata;
            r.rdy   = 2'b01 << p;
            r.err   = (delay < 0) ? (2'b01 << p) : 2'b00;
            r.rdata = model_rd;
            exp_resp.push_back(r);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((cmd_q[0].size() + cmd_q[1].size() + exp_mem.size() + mem_q.size()
                + exp_resp.size()) != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 3000) fail_msg("drain_timeout");
        repeat (4) @(posedge clk);
    endtask

    // Per-port requester: holds valid and fields until its req_ready pulse.
    for (genvar gi = 0; gi < 2; gi++) begin : g_drv
        logic              v  = 1'b0;
        logic              rw = 1'b0;
        logic [ADDR_W-1:0] a  = '0;
        logic [LINE_W-1:0] w  = '0;
        assign req_valid[gi]                  = v;
        assign req_rw[gi]                     = rw;
        assign req_addr[gi*ADDR_W +: ADDR_W]  = a;
        assign req_wdata[gi*LINE_W +: LINE_W] = w;

        initial begin
            cmd_t c;
            int   waited;
            forever begin
                @(posedge clk);
                #1;
                if (cmd_q[gi].size() > 0 && r_n) begin
                    c  = cmd_q[gi].pop_front();
                    v  = 1'b1;
                    rw = c.rw;
                    a  = c.addr;
                    w  = c.wdata;
                    @(negedge clk);
                    waited = 1;
                    while (!req_ready[gi] && r_n && waited < 300) begin
                        @(negedge clk);
                        waited++;
                    end
                    if (waited >= 300) fail_msg($sformatf("port%0d_ready_timeout", gi));
                end else begin
                    v = 1'b0;
                end
            end
        end
    end

    // Memory model: checks each new request, then answers after the queued delay.
    initial begin
        mresp_t m;
        cmd_t   e;
        int     hi;
        forever begin
            @(negedge clk);
            if (mem_valid) begin
                if (exp_mem.size() == 0 || mem_q.size() == 0) begin
                    fail_msg("mem_unexpected_request");
                    m.delay = -2;
                end else begin
                    e = exp_mem.pop_front();
                    m = mem_q.pop_front();
                    check("mem_req", {139'd0, mem_rw, mem_addr, mem_wdata}, {139'd0, e});
                end
                if (m.delay >= 1) begin
                    repeat (m.delay) @(posedge clk);
                    #1;
                    mem_ready = 1'b1;
                    mem_rdata = m.rdata;
                    @(posedge clk);
                    #1;
                    mem_ready = 1'b0;
                end else begin
                    hi = 1;
                    while (hi < 100) begin
                        @(negedge clk);
                        if (!mem_valid) break;
                        hi++;
                    end
                    if (m.delay == -1) check("timeout_len", 300'(hi), 300'(TIMEOUT));
                end
            end else if (stray_cnt != stray_done) begin
                @(posedge clk);
                #1;
                mem_ready = 1'b1;
                mem_rdata = 128'hBAD_BAD;
                @(posedge clk);
                #1;
                mem_ready = 1'b0;
                stray_done++;
            end
        end
    end

    // Response monitor.
    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            if (req_ready != 2'b00 || req_err != 2'b00) begin
                n_resp++;
                $display("resp %0d: ready=%b err=%b rdata=%h", n_resp, req_ready, req_err, req_rdata);
                if (exp_resp.size() == 0) begin
                    fail_msg($sformatf("unexpected_resp ready=%b err=%b", req_ready, req_err));
                end else begin
                    r = exp_resp.pop_front();
                    check("resp", {168'd0, req_ready, req_err, req_rdata}, {168'd0, r});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Stimulus.
    initial begin
        int n;
        #3 r_n = 1'b0;
        #1 check("reset_outputs",
                 {6'd0, mem_valid, mem_rw, mem_addr, mem_wdata, req_ready, req_err, req_rdata}, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        r_n = 1'b1;

        // Single read on port 0, answer 4 cycles after mem_valid.
        @(negedge clk);
        txn(0, 1'b0, 32'h0000_4010, 128'h0, 4, 128'hF0);
        wait_drain();

        // Write on port 1; req_rdata must keep 128'hF0.
        @(negedge clk);
        txn(1, 1'b1, 32'h0001_0020, 128'hDEAD, 2, 128'hBAD);
        wait_drain();

        // Both ports requesting continuously: grants alternate 0,1,0,1,0,1.
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            txn(0, 1'b0, 32'h0000_1000 + 32'(i * 16), 128'h0, 2, 128'hA0 + 128'(i));
            txn(1, 1'b1, 32'h0000_2000 + 32'(i * 16), 128'hB0 + 128'(i), 2, 128'hBAD);
        end
        wait_drain();

        // No answer: abort after TIMEOUT cycles with error pulse.
        @(negedge clk);
        txn(1, 1'b0, 32'h0000_3000, 128'h0, -1, 128'h0);
        wait_drain();

        // mem_ready on the last allowed cycle counts as success.
        @(negedge clk);
        txn(0, 1'b0, 32'h0000_3100, 128'h0, TIMEOUT - 1, 128'h7777);
        wait_drain();

        // Stray mem_ready while idle must not produce a response.
        @(negedge clk);
        stray_cnt++;
        n = 0;
        while (stray_done != stray_cnt && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) fail_msg("stray_timeout");
        repeat (3) @(negedge clk);
        txn(1, 1'b0, 32'h0000_3200, 128'h0, 1, 128'h1111);
        wait_drain();

        // Reset in the middle of an issue: outputs clear, port 0 wins next tie.
        @(negedge clk);
        txn(0, 1'b0, 32'h0000_3300, 128'h0, -2, 128'h0);
        n = 0;
        while (!mem_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) fail_msg("reset_issue_timeout");
        repeat (2) @(posedge clk);
        #2 r_n = 1'b0;
        #1 check("reset_mid_issue",
                 {6'd0, mem_valid, mem_rw, mem_addr, mem_wdata, req_ready, req_err, req_rdata}, '0);
        repeat (2) @(negedge clk);
        r_n = 1'b1;
        model_rd = '0;
        txn(0, 1'b0, 32'h0000_5000, 128'h0, 1, 128'hC0);
        txn(1, 1'b0, 32'h0000_6000, 128'h0, 1, 128'hC1);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
